// File: rtl/pcm_frame_unpacker_if.sv
// Receive byte-stream bundle from the Ethernet RX block into the PCM frame unpacker.
// The RX block drives it through the master modport; the unpacker samples it through the slave modport.
interface pcm_frame_unpacker_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;

  modport master (output rx_valid, rx_data, rx_sof, rx_eof, rx_err);
  modport slave  (input  rx_valid, rx_data, rx_sof, rx_eof, rx_err);
endinterface

// File: rtl/pcm_frame_unpacker.sv
// Strips the Ethernet header, packs payload into stereo 16-bit pairs, commits whole frames into a FIFO and plays one pair per pcm_en.
// Optional statistics counters are enabled with `define PCM_UNPACK_STATS_EN.
module pcm_frame_unpacker #(
  parameter int HDR_LEN = 14,
  parameter int PAIRS   = 28,
  parameter int FIFO_AW = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  pcm_frame_unpacker_if.slave       rx,
  input  logic                      i_pcm_en,
  output logic signed [15:0]        o_pcm_left,
  output logic signed [15:0]        o_pcm_right,
  output logic        [FIFO_AW:0]   o_fifo_level,
  output logic                      o_frame_ok,
  output logic                      o_underrun,
  output logic        [15:0]        o_cnt_drop,
  output logic        [15:0]        o_cnt_underrun
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int HW    = $clog2(HDR_LEN + 1);
  localparam int PW    = $clog2(PAIRS + 1);
  // A new frame fits only if the committed level leaves room for a full frame.
  localparam logic [FIFO_AW:0] LVL_MAX = (FIFO_AW+1)'(DEPTH - PAIRS);

  typedef enum logic [2:0] {IDLE, HDR, PAY, TAIL, DROP} state_t;

  state_t             r_state;
  logic [HW-1:0]      r_byte_cnt;
  logic [PW-1:0]      r_pair_cnt;
  logic [1:0]         r_bsel;
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_wr_sh;
  logic [FIFO_AW:0]   r_rd_ptr;
  logic               r_frame_ok;
  logic               r_underrun;
  logic               r_have;
  logic [23:0]        r_asm;
  logic [31:0]        r_rd_q;
  logic [31:0]        r_mem [DEPTH];

  logic [FIFO_AW:0]   w_level;
  logic               w_pop;
  logic               w_pay_byte;
  logic               w_we;
  logic [31:0]        w_wdata;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_pop      = i_pcm_en && (w_level != '0);
  assign w_pay_byte = (r_state == PAY) && rx.rx_valid && !rx.rx_sof && !rx.rx_eof;
  assign w_we       = w_pay_byte && (r_bsel == 2'd3);
  assign w_wdata    = {rx.rx_data, r_asm[23:16], r_asm[15:0]};

  // Frame parser FSM and FIFO pointers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_pair_cnt <= '0;
      r_bsel     <= '0;
      r_wr_ptr   <= '0;
      r_wr_sh    <= '0;
      r_rd_ptr   <= '0;
      r_frame_ok <= 1'b0;
      r_underrun <= 1'b0;
      r_have     <= 1'b0;
    end else begin
      r_frame_ok <= 1'b0;
      r_underrun <= i_pcm_en && (w_level == '0);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_have   <= 1'b1;
      end
      if (rx.rx_sof) begin
        // Any frame in flight is abandoned; the sof byte is header byte 0 of the new one.
        r_wr_sh    <= r_wr_ptr;
        r_pair_cnt <= '0;
        r_bsel     <= '0;
        r_byte_cnt <= HW'(1);
        r_state    <= (w_level <= LVL_MAX) ? HDR : DROP;
      end else if (rx.rx_eof) begin
        if (r_state == TAIL && !rx.rx_err) begin
          r_wr_ptr   <= r_wr_sh;
          r_frame_ok <= 1'b1;
        end else begin
          r_wr_sh <= r_wr_ptr;
        end
        r_state <= IDLE;
      end else if (rx.rx_valid) begin
        case (r_state)
          HDR: begin
            r_byte_cnt <= r_byte_cnt + HW'(1);
            if (r_byte_cnt == HW'(HDR_LEN - 1)) r_state <= PAY;
          end
          PAY: begin
            r_bsel <= r_bsel + 2'd1;
            if (r_bsel == 2'd3) begin
              r_wr_sh    <= r_wr_sh + 1'b1;
              r_pair_cnt <= r_pair_cnt + PW'(1);
              if (r_pair_cnt == PW'(PAIRS - 1)) r_state <= TAIL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sample assembly and RAM access (no reset on data)
  always_ff @(posedge i_clk) begin
    if (w_pay_byte) begin
      case (r_bsel)
        2'd0:    r_asm[7:0]   <= rx.rx_data;
        2'd1:    r_asm[15:8]  <= rx.rx_data;
        2'd2:    r_asm[23:16] <= rx.rx_data;
        default: ;
      endcase
    end
    if (w_we)  r_mem[r_wr_sh[FIFO_AW-1:0]] <= w_wdata;
    if (w_pop) r_rd_q <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
  end

  assign o_pcm_left   = r_have ? r_rd_q[15:0]  : '0;
  assign o_pcm_right  = r_have ? r_rd_q[31:16] : '0;
  assign o_fifo_level = w_level;
  assign o_frame_ok   = r_frame_ok;
  assign o_underrun   = r_underrun;

`ifdef PCM_UNPACK_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        w_drop;
  logic [15:0] r_cnt_drop;
  logic [15:0] r_cnt_underrun;

  assign w_drop = (r_state != IDLE) &&
                  (rx.rx_sof || (rx.rx_eof && !(r_state == TAIL && !rx.rx_err)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_drop     <= '0;
      r_cnt_underrun <= '0;
    end else begin
      if (w_drop) r_cnt_drop <= sat_inc(r_cnt_drop);
      if (i_pcm_en && (w_level == '0)) r_cnt_underrun <= sat_inc(r_cnt_underrun);
    end
  end

  assign o_cnt_drop     = r_cnt_drop;
  assign o_cnt_underrun = r_cnt_underrun;
`else
  assign o_cnt_drop     = '0;
  assign o_cnt_underrun = '0;
`endif

endmodule
